uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Receive-side counterpart of the 5-byte UART frame transmitter.
- Samples the serial line, deserialises 8N1 bytes and reassembles NBYTES consecutive bytes into one parallel word.
- Byte order: the first byte received is the least-significant byte, matching the transmitter, which sends Data[7:0] first.
- Sits between the board RX pin and the consumer logic, which sees one valid pulse per complete frame.

Parameters:
BAUD_DIV, 5208, sys_clk cycles per bit (50 MHz / 9600); must be >= 8
NBYTES, 5, bytes per frame; output width is 8*NBYTES
TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one frame before the partial frame is discarded

Ports:
sys_clk  input  1  system clock, all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
uart_rx  input  1  serial line, idle high, asynchronous to sys_clk
rx_data  output  8*NBYTES  last complete frame; byte k of the frame sits in bits [8k+7:8k]
rx_valid  output  1  one-cycle pulse: rx_data was updated
frame_err  output  1  one-cycle pulse: bad stop bit, or inter-byte timeout on a partial frame
busy  output  1  high while a byte is in progress or a partial frame is held

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, busy=0, byte count=0, bit FSM=IDLE. Both synchroniser flops reset to 1.
- Synchroniser: uart_rx passes through 2 flops (rx_s). Falling edge = previous rx_s is 1 and current rx_s is 0, detected only in IDLE.
- Bit FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a falling edge. The baud counter is cleared.
- START: at count BAUD_DIV/2-1 (mid start bit), sample rx_s.
  - rx_s=1: false start, go to IDLE, no error.
  - rx_s=0: go to DATA, counter cleared.
- DATA: sample rx_s every BAUD_DIV cycles, 8 samples, LSB first into a byte shift register. After the 8th sample go to STOP.
- STOP: sample once after BAUD_DIV cycles, i.e. mid stop bit.
  - rx_s=1: byte_done for one cycle.
  - rx_s=0: framing error. Byte discarded, byte count cleared, frame_err pulses the next cycle.
  - In both cases return to IDLE immediately, so a start bit beginning in the second half of the stop bit is caught.
- Assembly on byte_done:
  - Frame shift register updates as sr <= {byte, sr[8*NBYTES-1:8]}. Byte count increments.
  - When byte count = NBYTES-1 at byte_done: rx_data <= {byte, sr[8*NBYTES-1:8]} and rx_valid=1, both registered the cycle after the stop sample. Byte count wraps to 0.
  - rx_data holds its value until the next complete frame; errors never modify it.
- Timeout:
  - The idle counter runs only while the bit FSM is in IDLE and byte count > 0.
  - It clears on every falling-edge detection and whenever byte count = 0.
  - When it reaches TIMEOUT_BITS*BAUD_DIV-1: byte count cleared, frame_err pulses, sr contents ignored.
- Simultaneous events:
  - Timeout expiry in the same cycle as a falling edge: the timeout is applied first and the new byte becomes byte 0 of a fresh frame.
  - rx_valid and frame_err are never asserted in the same cycle.
- busy = (bit FSM != IDLE) or (byte count != 0), driven from registers.
- Reset mid-byte or mid-frame: everything returns to reset values. No rx_valid or frame_err is issued for the aborted frame.
- Line stuck low: after a framing error the FSM waits in IDLE for rx_s to go high and then fall again. No repeated errors occur.
- Widths: the baud counter is sized to hold BAUD_DIV-1. The timeout counter is sized to hold TIMEOUT_BITS*BAUD_DIV-1. Byte count is sized to hold NBYTES-1.

Test Plan (BAUD_DIV=16, NBYTES=5, TIMEOUT_BITS=20):
1. Send bytes 9A,78,56,34,12 back-to-back, 8N1.
   -> rx_data=40'h123456789A.
   -> rx_valid is high for exactly 1 cycle, 1 cycle after the 5th stop-bit sample.
   -> frame_err stays 0; busy is 0 afterwards.
2. Send two frames back-to-back: 11..55, then AA..EE with zero idle gap.
   -> Two rx_valid pulses.
   -> rx_data=40'h5544332211, then 40'hEEDDCCBBAA.
3. Pulse uart_rx low for 4 cycles while idle.
   -> False start, no byte accepted, frame_err=0, busy returns to 0.
4. Send byte 3C with its stop bit held low, then a full 5-byte frame.
   -> One frame_err pulse; byte count is 0 after the error.
   -> The following frame is received correctly.
5. Send 2 bytes, then idle for 320 cycles, then 5 bytes 01..05.
   -> frame_err pulses at the 320th idle cycle.
   -> rx_data=40'h0504030201; the stale bytes are not merged.
6. Assert rst_n low during bit 3 of the 3rd byte, then send a full frame.
   -> All outputs are at reset values during reset.
   -> The first frame after reset is received correctly.
   -> No rx_valid or frame_err pulse occurs for the aborted frame.

Source files
------------

// File: rtl/uart_frame_rx.sv
// 8N1 UART receiver that reassembles NBYTES consecutive bytes (first byte = LSB)
// into one parallel word, with framing-error and inter-byte timeout detection.
module uart_frame_rx #(
  parameter int unsigned BAUD_DIV     = 5208,
  parameter int unsigned NBYTES       = 5,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic [8*NBYTES-1:0]   rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned FW     = 8 * NBYTES;
  localparam int unsigned BW     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned TO_CYC = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam int unsigned CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          r_rx_meta, r_rx_s, r_rx_prev;
  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_byte;
  // Only the NBYTES-1 most recent bytes are kept; the in-flight byte completes the word.
  logic [FW-9:0] r_sr;
  logic [CW-1:0] r_byte_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic [FW-1:0] r_rx_data;
  logic          r_rx_valid, r_frame_err;

  logic          w_fall, w_baud_clr, w_data_smp, w_byte_done, w_stop_err, w_timeout;
  logic [FW-1:0] w_frame;

  assign w_fall    = r_rx_prev & ~r_rx_s;
  assign w_frame   = {r_byte, r_sr};
  assign w_timeout = (r_state == IDLE) && (r_byte_cnt != '0) && (r_idle_cnt == TO_LAST);

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE) || (r_byte_cnt != '0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_clr  = 1'b0;
    w_data_smp  = 1'b0;
    w_byte_done = 1'b0;
    w_stop_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_baud_clr  = 1'b1;
        end
      end
      START: begin
        if (r_baud_cnt == BAUD_HALF) begin
          w_baud_clr  = 1'b1;
          w_state_nxt = r_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_baud_cnt == BAUD_LAST) begin
          w_baud_clr = 1'b1;
          w_data_smp = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (r_baud_cnt == BAUD_LAST) begin
          w_baud_clr  = 1'b1;
          w_state_nxt = IDLE;
          if (r_rx_s) w_byte_done = 1'b1;
          else        w_stop_err  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte     <= '0;
    end else begin
      if (w_baud_clr || r_state == IDLE) r_baud_cnt <= '0;
      else                               r_baud_cnt <= r_baud_cnt + BW'(1);
      if (r_state == START)  r_bit_cnt <= '0;
      else if (w_data_smp)   r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_data_smp) r_byte <= {r_rx_s, r_byte[7:1]};
    end
  end

  // Timeout takes priority; it is only possible in IDLE so it never meets a stop sample.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_byte_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_timeout || w_stop_err) begin
        r_byte_cnt  <= '0;
        r_frame_err <= 1'b1;
      end else if (w_byte_done) begin
        r_sr <= w_frame[FW-1:8];
        if (r_byte_cnt == CNT_LAST) begin
          r_rx_data  <= w_frame;
          r_rx_valid <= 1'b1;
          r_byte_cnt <= '0;
        end else begin
          r_byte_cnt <= r_byte_cnt + CW'(1);
        end
      end
      if (r_state != IDLE || r_byte_cnt == '0 || w_fall || w_timeout) r_idle_cnt <= '0;
      else                                                           r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboarded bench for uart_frame_rx: frame-level reference model predicts
// rx_valid/frame_err events; a monitor pops and compares them as they appear.
module tb_uart_frame_rx;

  localparam int BAUD = 16;
  localparam int NB   = 5;
  localparam int TOB  = 20;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic [39:0] rx_data;
  logic        rx_valid, frame_err, busy;

  uart_frame_rx #(.BAUD_DIV(BAUD), .NBYTES(NB), .TIMEOUT_BITS(TOB)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        is_err;
    logic [39:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] acc[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [39:0] hold = '0;
  exp_t       mon_e;
  int         last_err_at;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every output event must match the oldest predicted event.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      hold = '0;
    end else if (rx_valid || frame_err) begin
      chk("valid_err_overlap", 40'(rx_valid & frame_err), 40'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got valid=%b err=%b data=%h, required no event",
                 rx_valid, frame_err, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind_is_err", 40'(frame_err), 40'(mon_e.is_err));
        if (!mon_e.is_err) begin
          chk("rx_data", rx_data, mon_e.data);
          hold = mon_e.data;
        end else begin
          chk("rx_data_hold_on_err", rx_data, hold);
        end
      end
    end
  end

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    exp_t e;
    if (!ok) begin
      acc.delete();
      push_err();
    end else begin
      acc.push_back(b);
      if (acc.size() == NB) begin
        e.is_err = 1'b0;
        e.data   = '0;
        foreach (acc[k]) e.data[8*k +: 8] = acc[k];
        exp_q.push_back(e);
        acc.delete();
      end
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (BAUD) @(negedge sys_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    model_byte(b, ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(ok);
  endtask

  task automatic send_frame(input logic [39:0] w);
    for (int k = 0; k < NB; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  // Gaps here are either well below or well above the timeout, never near it.
  task automatic idle(input int n);
    if (n >= 300 && acc.size() > 0) begin
      push_err();
      acc.delete();
    end
    uart_rx     = 1'b1;
    last_err_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge sys_clk);
      if (frame_err && last_err_at < 0) last_err_at = i;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    n_vec++;
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         g, r;
    logic [39:0] w;

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_rx_data", rx_data, 40'd0);
    chk("reset_rx_valid", 40'(rx_valid), 40'd0);
    chk("reset_frame_err", 40'(frame_err), 40'd0);
    chk("reset_busy", 40'(busy), 40'd0);
    rst_n = 1'b1;
    idle(10);

    // 1: single frame
    send_frame(40'h123456789A);
    idle(40);
    chk("t1_busy_after", 40'(busy), 40'd0);
    chk("t1_pending", 40'(exp_q.size()), 40'd0);

    // 2: two frames, no gap
    send_frame(40'h5544332211);
    send_frame(40'hEEDDCCBBAA);
    idle(40);
    chk("t2_pending", 40'(exp_q.size()), 40'd0);

    // 3: false start
    uart_rx = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("t3_busy_in_start", 40'(busy), 40'd1);
    idle(40);
    chk("t3_busy_after", 40'(busy), 40'd0);

    // 4: bad stop bit, then a good frame
    send_byte(8'h3C, 1'b0);
    idle(20);
    chk("t4_busy_after_err", 40'(busy), 40'd0);
    send_frame(40'h0FEDCBA987);
    idle(40);
    chk("t4_pending", 40'(exp_q.size()), 40'd0);

    // 5: partial frame timeout
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    idle(320);
    n_vec++;
    if (!(last_err_at >= 305 && last_err_at <= 325)) begin
      n_bad++;
      $display("FAIL t5_timeout_cycle: got %0d, required 305..325", last_err_at);
    end
    chk("t5_busy_after", 40'(busy), 40'd0);
    send_frame(40'h0504030201);
    idle(40);

    // 6: reset during bit 3 of the 3rd byte
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    b = 8'h96;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    uart_rx = b[3];
    repeat (BAUD / 2) @(negedge sys_clk);
    rst_n = 1'b0;
    acc.delete();
    repeat (3) @(negedge sys_clk);
    chk("t6_rst_rx_data", rx_data, 40'd0);
    chk("t6_rst_rx_valid", 40'(rx_valid), 40'd0);
    chk("t6_rst_frame_err", 40'(frame_err), 40'd0);
    chk("t6_rst_busy", 40'(busy), 40'd0);
    rst_n = 1'b1;
    idle(20);
    send_frame(40'h7766554433);
    idle(40);
    chk("t6_pending", 40'(exp_q.size()), 40'd0);

    // Randomised byte stream with occasional bad stops and long gaps
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 11) != 0);
      send_byte(b, ok);
      if (!ok) begin
        g = $urandom_range(16, 60);
      end else begin
        r = $urandom_range(0, 9);
        if (r == 0)     g = 400;
        else if (r < 5) g = 0;
        else            g = $urandom_range(1, 150);
      end
      if (g > 0) idle(g);
    end
    idle(400);
    w = {$urandom, 8'($urandom)};
    send_frame(w);
    idle(40);
    chk("final_pending", 40'(exp_q.size()), 40'd0);
    chk("final_busy", 40'(busy), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
